ifetch_queue: RTL



---
 rtl/ifetch_pkg.sv | 17 +
 rtl/ifetch_fifo.sv | 50 +++++
 rtl/ifetch_queue.sv | 108 ++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// Shared types for the instruction fetch stage: FSM state, queue entry layout, instruction size.
package ifetch_pkg;

    localparam int unsigned INST_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO of fetched {pc, inst} entries; flush overrides push and pop.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  fetch_entry_t             push_entry_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output fetch_entry_t             head_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    fetch_entry_t mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, rd_ptr_q;
    logic         do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign do_push = push_i && (count_o != FULL_COUNT);
    assign do_pop  = pop_i && (count_o != '0);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_entry_i;
                wr_ptr_q                <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: owns fetch PC, keeps one imem read outstanding, queues words for decode.
// Build option: IFETCH_STALL_CNT_EN adds stall_count, a saturating count of empty-queue cycles.
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
`ifdef IFETCH_STALL_CNT_EN
    ,
    output logic [31:0] stall_count
`endif
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] count;
    logic          req_ok, push, pop, flush;
    fetch_entry_t  push_entry, head;

    assign req_ok     = (state_q == IDLE) && (count != FULL_COUNT) && !redirect_valid;
    // Gated by reset_n so the request line drops the instant reset is asserted.
    assign imem_req   = reset_n && req_ok;
    assign imem_addr  = imem_req ? fetch_pc_q : '0;
    assign inst_valid = (count != '0);
    assign pop        = inst_valid && inst_ready && !redirect_valid;
    assign push_entry = '{pc: fetch_pc_q, inst: imem_rdata};
    assign inst_data  = head.inst;
    assign inst_pc    = head.pc;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        push       = 1'b0;
        flush      = 1'b0;
        case (state_q)
            IDLE: if (req_ok) state_d = WAIT;
            WAIT: if (imem_ack) begin
                push       = 1'b1;
                fetch_pc_d = fetch_pc_q + INST_BYTES;
                state_d    = IDLE;
            end
            DROP: if (imem_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A redirect discards any in-flight word; an ack arriving with it retires the stale request.
        if (redirect_valid) begin
            flush      = 1'b1;
            push       = 1'b0;
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            if (state_q == WAIT || state_q == DROP) begin
                state_d = imem_ack ? IDLE : DROP;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    ifetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i       (clock),
        .rst_ni      (reset_n),
        .push_i      (push),
        .pop_i       (pop),
        .flush_i     (flush),
        .push_entry_i(push_entry),
        .count_o     (count),
        .head_o      (head)
    );

`ifdef IFETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else if (!inst_valid && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_count = stall_cnt_q;
`endif

endmodule
